// File: rtl/mdu_e_pkg.sv
// rtl/mdu_e_pkg.sv - shared MDU operation codes, default latencies and decode helpers
// Purpose: MDUOp encoding shared with the control unit and the D->E pipeline
//          register, plus the default busy-cycle counts for the MDU.
// Ports:   none (package)
package mdu_e_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Any real MDU instruction; codes 9..15 decode as NONE.
   function automatic logic is_mdu(input logic [3:0] op);
      return (op >= MDU_MULT) && (op <= MDU_MTLO);
   endfunction

   // Operations that occupy the multi-cycle datapath.
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op >= MDU_MULT) && (op <= MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_e_calc.sv
// rtl/mdu_e_calc.sv - combinational product/quotient/remainder for the MDU
// Purpose: computes the HI/LO result of mult/multu/div/divu in one pass and
//          flags a divide by zero.
// Ports:   i_op        MDU operation code
//          i_a, i_b    rs / rt operands
//          o_hi, o_lo  result split as it will land in HI/LO
//          o_div_zero  divide op with a zero divisor
module mdu_e_calc
   import mdu_e_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_div_zero
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_b_safe;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_q_s;
   logic [31:0] w_r_s;
   logic [31:0] w_q_u;
   logic [31:0] w_r_u;

   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // A zero divisor is replaced so the dividers never see it; the result is
   // discarded at commit anyway.
   assign w_b_safe = (i_b == 32'd0) ? 32'd1 : i_b;

   // Signed divide via magnitudes: truncation toward zero, remainder follows
   // the dividend, and 0x80000000 / -1 wraps instead of faulting.
   assign w_a_mag = i_a[31]      ? (32'd0 - i_a)      : i_a;
   assign w_b_mag = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
   assign w_q_mag = w_a_mag / w_b_mag;
   assign w_r_mag = w_a_mag % w_b_mag;
   assign w_q_s   = (i_a[31] ^ w_b_safe[31]) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_r_s   = i_a[31] ? (32'd0 - w_r_mag) : w_r_mag;

   assign w_q_u = i_a / w_b_safe;
   assign w_r_u = i_a % w_b_safe;

   always_comb begin
      o_hi = 32'd0;
      o_lo = 32'd0;
      case (i_op)
         MDU_MULT:  {o_hi, o_lo} = w_prod_s;
         MDU_MULTU: {o_hi, o_lo} = w_prod_u;
         MDU_DIV: begin
            o_hi = w_r_s;
            o_lo = w_q_s;
         end
         MDU_DIVU: begin
            o_hi = w_r_u;
            o_lo = w_q_u;
         end
         default: ;
      endcase
   end

   assign o_div_zero = (i_b == 32'd0) && ((i_op == MDU_DIV) || (i_op == MDU_DIVU));

endmodule

// File: rtl/mdu_e.sv
// rtl/mdu_e.sv - execute-stage multiply/divide unit with HI/LO and stall request
// Purpose: launches mult/div with a fixed latency, commits into HI/LO, serves
//          mfhi/mflo/mthi/mtlo and asks the D stage to stall while busy.
// Ports:   clk        rising-edge clock
//          reset      asynchronous active-low reset
//          MDUOp_E    MDU op of the instruction in E
//          A_E, B_E   forwarded rs / rt values
//          MDUOp_D    MDU op of the instruction in D
//          start      mult/div launched this cycle
//          busy       mult/div in flight
//          HI, LO     architectural HI/LO
//          MDUOut_E   mfhi/mflo result, 0 otherwise
//          Stall_MDU  D-stage stall request
module mdu_e
   import mdu_e_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOp_E,
   input  logic [31:0] A_E,
   input  logic [31:0] B_E,
   input  logic [3:0]  MDUOp_D,
   output logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut_E,
   output logic        Stall_MDU
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] r_count;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_hi_n;
   logic [31:0]   r_lo_n;
   logic          r_div_zero;

   logic [31:0]   w_calc_hi;
   logic [31:0]   w_calc_lo;
   logic          w_calc_dz;
   logic          w_is_div;
   logic [CW-1:0] w_load;
   logic          w_commit;

   mdu_e_calc u_mdu_calc (
      .i_op       (MDUOp_E),
      .i_a        (A_E),
      .i_b        (B_E),
      .o_hi       (w_calc_hi),
      .o_lo       (w_calc_lo),
      .o_div_zero (w_calc_dz)
   );

   assign busy     = (r_count != '0);
   assign start    = is_muldiv(MDUOp_E) && !busy;
   assign w_is_div = (MDUOp_E == MDU_DIV) || (MDUOp_E == MDU_DIVU);
   assign w_load   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
   // Last busy cycle: the shadow result becomes architectural on this edge.
   assign w_commit = (r_count == CW'(1)) && !r_div_zero;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_hi_n     <= 32'd0;
         r_lo_n     <= 32'd0;
         r_div_zero <= 1'b0;
      end else if (start) begin
         r_count    <= w_load;
         r_hi_n     <= w_calc_hi;
         r_lo_n     <= w_calc_lo;
         r_div_zero <= w_calc_dz;
      end else if (busy) begin
         // Anything else arriving in E while busy is dropped.
         r_count <= r_count - CW'(1);
         if (w_commit) begin
            r_hi <= r_hi_n;
            r_lo <= r_lo_n;
         end
      end else begin
         if (MDUOp_E == MDU_MTHI) begin
            r_hi <= A_E;
         end
         if (MDUOp_E == MDU_MTLO) begin
            r_lo <= A_E;
         end
      end
   end

   assign HI = r_hi;
   assign LO = r_lo;

   always_comb begin
      MDUOut_E = 32'd0;
      if (MDUOp_E == MDU_MFHI) begin
         MDUOut_E = r_hi;
      end else if (MDUOp_E == MDU_MFLO) begin
         MDUOut_E = r_lo;
      end
   end

   assign Stall_MDU = is_mdu(MDUOp_D) && (start || busy);

endmodule

// File: doc/mdu_e.md
# mdu_e

Execute-stage multiply/divide unit for the P6 pipeline. It consumes the MDU control and operands that the D→E pipeline register delivers to E. It runs mult/multu/div/divu with a fixed multi-cycle latency, owns the HI/LO registers, serves mfhi/mflo/mthi/mtlo, and raises the MDU stall request back to the D-stage hazard unit.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- MDUOp_E  in  4  MDU operation of the instruction currently in E
- A_E  in  32  forwarded rs value
- B_E  in  32  forwarded rt value
- MDUOp_D  in  4  MDU operation of the instruction in D, for stall generation
- start  out  1  a mult/div is launched this cycle
- busy  out  1  a mult/div is in flight
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- MDUOut_E  out  32  mfhi/mflo result for the E-stage result mux
- Stall_MDU  out  1  D-stage stall request

## Operation
- MDUOp encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Values 9–15 are treated as NONE.
- start = MDUOp_E ∈ {MULT, MULTU, DIV, DIVU} & ~busy.
- On a start edge:
  - Latch the result into shadow registers hi_n/lo_n.
  - MULT: signed 64-bit product, HI gets [63:32], LO gets [31:0].
  - MULTU: unsigned 64-bit product, same split.
  - DIV: signed quotient truncated toward zero goes to LO; remainder takes the sign of the dividend and goes to HI.
  - DIVU: unsigned quotient to LO, remainder to HI.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- Divide by zero (B_E==0): the op still occupies the full DIV_CYCLES busy period; HI/LO stay unchanged at commit.
- busy = (count != 0). The counter decrements every cycle while nonzero.
- Commit: on the edge where count goes 1→0, HI←hi_n and LO←lo_n, unless the op was a divide by zero.
- MTHI/MTLO: when not busy, write A_E into HI/LO on the clock edge. While busy, they are ignored.
- MFHI/MFLO: MDUOut_E = HI or LO, combinational from the architectural registers. Otherwise MDUOut_E = 0.
- MDU ops arriving in E while busy (mult/div, mt, or mf) are ignored. Stall_MDU guarantees this does not occur in legal flow.
- Stall_MDU = (MDUOp_D ∈ 1..8) & (start | busy).
- Reset (asserted low at any time, including mid-operation):
  - count=0, busy=0, HI=LO=0, hi_n=lo_n=0.
  - The in-flight result is discarded.
  - start follows its combinational definition.

## Timing
- For a start in cycle T:
  - busy=1 for cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - The new HI/LO are visible from cycle T+N+1, when busy=0.
- Back-to-back mult/div: the next start is possible in cycle T+N+1.
- mtlo/mthi in cycle T: the new value is visible at HI/LO/MDUOut_E in T+1.
- mflo in the cycle immediately after commit returns the new value.
- Stall_MDU is combinational and asserted in cycle T (start) and in T+1…T+N.
- Reset-value summary: start=combinational, busy=0, HI=0, LO=0, MDUOut_E=0 unless MFHI/MFLO, Stall_MDU=0 unless start.

## Structure
- Shared definitions package/header holds:
  - MDUOp codes (MDU_NONE … MDU_MTLO)
  - default MULT_CYCLES/DIV_CYCLES
  - an is_mdu(op) helper condition
- These codes must match the control unit and the D→E pipeline register fields.
- One natural sub-module, mdu_calc: the combinational 64-bit product/quotient/remainder with a div-by-zero flag.
- mdu_e keeps the counter, shadow registers, HI/LO, and stall logic.

## Test plan
- MULT with A=0xFFFFFFFF, B=2:
  - start=1 in T; busy=1 for T+1…T+5.
  - From T+6: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with the same operands: from T+6, HI=0x00000001, LO=0xFFFFFFFE.
- DIV with A=-7, B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with A=7, B=0, after mtlo 0x1234 and mthi 0x5678:
  - busy for 10 cycles.
  - Afterwards HI=0x5678, LO=0x1234, unchanged.
- Stall and ignore behaviour:
  - mthi with A_E=0xDEADBEEF, then mfhi next cycle: MDUOut_E=0xDEADBEEF.
  - MDUOp_D=MFLO during a mult's busy window: Stall_MDU=1 every cycle until busy drops.
- Reset mid-operation:
  - Start DIV, assert reset low at T+3.
  - busy=0 and HI=LO=0 immediately.
  - After release, no commit ever occurs.
